// File: rtl/relu_layer_collect.sv
// relu_layer_collect: captures per-neuron pre-activations, applies ReLU,
// buffers one layer and scans the buffer for the argmax once it is full.
module relu_layer_collect #(
    parameter int N_NEURONS = 8,
    parameter int DATA_W    = 64,
    parameter int IDX_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_act_1,
    input  logic [DATA_W-1:0] act_out,
    input  logic [31:0]       n_n1,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              layer_done,
    output logic [IDX_W-1:0]  argmax_idx,
    output logic [DATA_W-1:0] max_val,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        COLLECT,
        SCAN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic                 done_q;
    logic [DATA_W-1:0]    mem [N_NEURONS];
    logic [N_NEURONS-1:0] valid;

    logic                 skid_v;
    logic [DATA_W-1:0]    skid_val;
    logic [IDX_W-1:0]     skid_idx;

    logic [IDX_W-1:0]     scan_k;
    logic [DATA_W-1:0]    run_max;
    logic [IDX_W-1:0]     run_idx;

    logic                 cap;
    logic                 idx_ok;
    logic [IDX_W-1:0]     cap_idx;
    logic [DATA_W-1:0]    relu_val;
    logic                 last_k;
    logic [DATA_W-1:0]    cur_val;
    logic [DATA_W-1:0]    cand_val;
    logic [IDX_W-1:0]     cand_idx;

    assign cap      = done_act_1 && !done_q;
    assign idx_ok   = n_n1 < 32'(N_NEURONS);
    assign cap_idx  = n_n1[IDX_W-1:0];
    assign relu_val = act_out[DATA_W-1] ? '0 : act_out;
    assign last_k   = scan_k == IDX_W'(N_NEURONS - 1);

    assign layer_done = state == DONE;
    assign busy       = state != COLLECT;

    // Non-negative doubles order the same as their raw bit patterns.
    always_comb begin
        cur_val  = mem[scan_k];
        cand_val = run_max;
        cand_idx = run_idx;
        if (scan_k == '0 || cur_val > run_max) begin
            cand_val = cur_val;
            cand_idx = scan_k;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            COLLECT: if (&valid) state_nx = SCAN;
            SCAN:    if (last_k) state_nx = DONE;
            DONE:    state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            done_q     <= 1'b0;
            valid      <= '0;
            skid_v     <= 1'b0;
            skid_val   <= '0;
            skid_idx   <= '0;
            scan_k     <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            rd_data    <= '0;
            argmax_idx <= '0;
            max_val    <= '0;
            err        <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            done_q  <= done_act_1;
            rd_data <= mem[rd_addr];
            if (cap && !idx_ok) begin
                err <= 1'b1;
            end
            unique case (state)
                COLLECT: begin
                    scan_k <= '0;
                    if (skid_v) begin
                        mem[skid_idx]   <= skid_val;
                        valid[skid_idx] <= 1'b1;
                        skid_v          <= 1'b0;
                    end
                    if (cap && idx_ok) begin
                        mem[cap_idx]   <= relu_val;
                        valid[cap_idx] <= 1'b1;
                    end
                end
                SCAN, DONE: begin
                    if (state == SCAN) begin
                        run_max <= cand_val;
                        run_idx <= cand_idx;
                        scan_k  <= scan_k + 1'b1;
                        if (last_k) begin
                            max_val    <= cand_val;
                            argmax_idx <= cand_idx;
                        end
                    end else begin
                        valid <= '0;
                    end
                    // Next-layer results arriving while busy wait in the skid.
                    if (cap && idx_ok) begin
                        if (skid_v) begin
                            err <= 1'b1;
                        end else begin
                            skid_v   <= 1'b1;
                            skid_val <= relu_val;
                            skid_idx <= cap_idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
